// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Raster timing source for the ADV7123 DAC path. It divides the system clock
// down to a pixel rate and scans DrawX/DrawY across the full raster. It also
// generates the sync, blank and pixel-clock pins plus a once-per-frame tick.
// Every output is registered and derived from the same next-state counters,
// so the sync/blank pins always describe the DrawX/DrawY presented with them.

module vga_timing_gen #(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       Clk,
  input  logic       Reset,
  output logic       pix_tick,
  output logic       VGA_CLK,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       frame_start
);

  localparam int DIV_W = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

  localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [DIV_W-1:0] div_r;
  logic [DIV_W-1:0] div_nxt_s;
  logic             pix_tick_r;
  logic             vga_clk_r;
  logic             hs_r;
  logic             vs_r;
  logic             blank_n_r;
  logic             frame_start_r;
  logic [9:0]       x_r;
  logic [9:0]       y_r;
  logic [9:0]       x_nxt_s;
  logic [9:0]       y_nxt_s;
  logic             hs_nxt_s;
  logic             vs_nxt_s;
  logic             blank_n_nxt_s;
  logic             frame_start_nxt_s;

  // Next-state for the divider, raster counters and all derived pins.
  always_comb begin
    div_nxt_s         = DIV_ZERO;
    x_nxt_s           = x_r;
    y_nxt_s           = y_r;
    hs_nxt_s          = 1'b1;
    vs_nxt_s          = 1'b1;
    blank_n_nxt_s     = 1'b1;
    frame_start_nxt_s = 1'b0;

    if (div_r == DIV_LAST) begin
      div_nxt_s = DIV_ZERO;
    end else begin
      div_nxt_s = div_r + DIV_ONE;
    end

    // The counters move only on the edge that closes a pix_tick cycle.
    if (pix_tick_r) begin
      if (x_r == H_LAST) begin
        x_nxt_s = 10'd0;
        if (y_r == V_LAST) begin
          y_nxt_s = 10'd0;
        end else begin
          y_nxt_s = y_r + 10'd1;
        end
      end else begin
        x_nxt_s = x_r + 10'd1;
        y_nxt_s = y_r;
      end
    end else begin
      x_nxt_s = x_r;
      y_nxt_s = y_r;
    end

    hs_nxt_s      = !((x_nxt_s >= HS_START) && (x_nxt_s < HS_END));
    vs_nxt_s      = !((y_nxt_s >= VS_START) && (y_nxt_s < VS_END));
    blank_n_nxt_s = (x_nxt_s < H_VIS) && (y_nxt_s < V_VIS);

    // Only the tick edge that lands on the first pixel of v sync starts a frame.
    if (pix_tick_r && (x_nxt_s == 10'd0) && (y_nxt_s == VS_START)) begin
      frame_start_nxt_s = 1'b1;
    end else begin
      frame_start_nxt_s = 1'b0;
    end
  end

  // State register: divider, raster position and every registered output pin.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      div_r         <= DIV_ZERO;
      pix_tick_r    <= 1'b0;
      vga_clk_r     <= 1'b0;
      x_r           <= 10'd0;
      y_r           <= 10'd0;
      hs_r          <= 1'b1;
      vs_r          <= 1'b1;
      blank_n_r     <= 1'b1;
      frame_start_r <= 1'b0;
    end else begin
      div_r         <= div_nxt_s;
      pix_tick_r    <= (div_nxt_s == DIV_LAST);
      vga_clk_r     <= (div_nxt_s >= DIV_HALF);
      x_r           <= x_nxt_s;
      y_r           <= y_nxt_s;
      hs_r          <= hs_nxt_s;
      vs_r          <= vs_nxt_s;
      blank_n_r     <= blank_n_nxt_s;
      frame_start_r <= frame_start_nxt_s;
    end
  end

  assign pix_tick    = pix_tick_r;
  assign VGA_CLK     = vga_clk_r;
  assign VGA_HS      = hs_r;
  assign VGA_VS      = vs_r;
  assign VGA_BLANK_N = blank_n_r;
  assign VGA_SYNC_N  = 1'b0;
  assign DrawX       = x_r;
  assign DrawY       = y_r;
  assign frame_start = frame_start_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
// Directed bench for vga_timing_gen. It uses a default 640x480 instance for
// reset and line timing, and a tiny 14x7 raster instance for frame-level
// behaviour, the wrap corner, and the mid-v-sync reset case.

module tb_vga_timing_gen;

  logic       Clk = 1'b0;
  logic       rst_a;
  logic       rst_b;

  logic       a_tick, a_vclk, a_hs, a_vs, a_blank_n, a_sync_n, a_fs;
  logic [9:0] a_x, a_y;
  logic       b_tick, b_vclk, b_hs, b_vs, b_blank_n, b_sync_n, b_fs;
  logic [9:0] b_x, b_y;

  vga_timing_gen dut_a (
    .Clk(Clk), .Reset(rst_a), .pix_tick(a_tick), .VGA_CLK(a_vclk),
    .VGA_HS(a_hs), .VGA_VS(a_vs), .VGA_BLANK_N(a_blank_n), .VGA_SYNC_N(a_sync_n),
    .DrawX(a_x), .DrawY(a_y), .frame_start(a_fs)
  );

  vga_timing_gen #(
    .CLK_DIV(4), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
  ) dut_b (
    .Clk(Clk), .Reset(rst_b), .pix_tick(b_tick), .VGA_CLK(b_vclk),
    .VGA_HS(b_hs), .VGA_VS(b_vs), .VGA_BLANK_N(b_blank_n), .VGA_SYNC_N(b_sync_n),
    .DrawX(b_x), .DrawY(b_y), .frame_start(b_fs)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int         n;
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       blank_n;
    logic       vclk;
    logic       tick;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_n   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
    edge_n++;
  endtask

  vec_t tbl[14];

  initial begin
    int p, ex, ey, fs_first, fs_prev, guard;

    // Default instance, CLK_DIV=2: edge n after release shows pixel n/2.
    tbl[0]  = '{1,    10'd0,   10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[1]  = '{2,    10'd1,   10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{3,    10'd1,   10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[3]  = '{1278, 10'd639, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1280, 10'd640, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1311, 10'd655, 10'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[6]  = '{1312, 10'd656, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1401, 10'd700, 10'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[8]  = '{1502, 10'd751, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1504, 10'd752, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1598, 10'd799, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1600, 10'd0,   10'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{2912, 10'd656, 10'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{3200, 10'd0,   10'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (3) step();
    @(negedge Clk) rst_a = 1'b1;
    repeat (300) step();

    // Reset dropped mid-line: every pin must snap to its reset value at once.
    @(negedge Clk) rst_a = 1'b0;
    #1;
    check("rst_x", a_x, 0);
    check("rst_y", a_y, 0);
    check("rst_vclk", a_vclk, 0);
    check("rst_hs", a_hs, 1);
    check("rst_vs", a_vs, 1);
    check("rst_blank", a_blank_n, 1);
    check("rst_tick", a_tick, 0);
    check("rst_fs", a_fs, 0);
    check("sync_n", a_sync_n, 0);
    repeat (3) step();
    check("rst_hold_x", a_x, 0);
    check("rst_hold_vclk", a_vclk, 0);

    // Table-driven line checks on the default raster.
    @(negedge Clk) rst_a = 1'b1;
    edge_n = 0;
    for (int i = 0; i < 14; i++) begin
      while (edge_n < tbl[i].n) step();
      check("tbl_x", a_x, tbl[i].x);
      check("tbl_y", a_y, tbl[i].y);
      check("tbl_hs", a_hs, tbl[i].hs);
      check("tbl_vs", a_vs, tbl[i].vs);
      check("tbl_blank", a_blank_n, tbl[i].blank_n);
      check("tbl_vclk", a_vclk, tbl[i].vclk);
      check("tbl_tick", a_tick, tbl[i].tick);
      check("tbl_fs", a_fs, 0);
    end

    // Tiny raster, CLK_DIV=4: two whole frames against a closed-form model.
    @(negedge Clk) rst_b = 1'b1;
    edge_n  = 0;
    fs_prev = -1;
    for (int n = 1; n <= 788; n++) begin
      step();
      p  = n / 4;
      ex = p % 14;
      ey = (p / 14) % 7;
      check("frm_x", b_x, ex);
      check("frm_y", b_y, ey);
      check("frm_hs", b_hs, ((ex >= 10) && (ex <= 11)) ? 0 : 1);
      check("frm_vs", b_vs, (ey == 5) ? 0 : 1);
      check("frm_blank", b_blank_n, ((ex < 8) && (ey < 4)) ? 1 : 0);
      check("frm_fs", b_fs, ((n % 4 == 0) && (ex == 0) && (ey == 5)) ? 1 : 0);
      check("frm_vclk", b_vclk, ((n % 4) >= 2) ? 1 : 0);
      if (b_fs) begin
        if (fs_prev >= 0) check("frm_period", n - fs_prev, 392);
        fs_prev = n;
      end
      if (n == 388) begin
        check("corner_x_pre", b_x, 13);
        check("corner_y_pre", b_y, 6);
      end
      if (n == 392) begin
        check("corner_x", b_x, 0);
        check("corner_y", b_y, 0);
        check("corner_blank", b_blank_n, 1);
        check("corner_hs", b_hs, 1);
        check("corner_vs", b_vs, 1);
      end
    end
    check("frm_last_fs", fs_prev, 672);

    // Reset pulse during v sync: VS releases immediately and the frame restarts.
    guard = 0;
    while ((b_y != 10'd5) && (guard < 400)) begin
      step();
      guard++;
    end
    check("wait_vsync_y", b_y, 5);
    check("vsync_low", b_vs, 0);
    @(negedge Clk) rst_b = 1'b0;
    #1;
    check("vrst_vs", b_vs, 1);
    check("vrst_y", b_y, 0);
    check("vrst_fs", b_fs, 0);
    @(negedge Clk) rst_b = 1'b1;
    edge_n   = 0;
    fs_first = -1;
    for (int n = 1; n <= 300; n++) begin
      step();
      if (b_fs && (fs_first < 0)) fs_first = n;
    end
    check("vrst_first_fs", fs_first, 280);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
